conv_symbol_deserializer: RTL and testbench

Receive-side counterpart of the TTC convolutional-symbol serializer. It takes the single-line hard-decision symbol stream, which alternates the G0 symbol with the inverted G1 symbol, and reassembles it into (c0, c1) symbol pairs for the Viterbi decoder. It restores the G1 polarity, supports pair-phase slipping on request from the decoder's sync logic, and presents pairs through a one-entry valid/ready holding register with overrun detection and a pair counter.

---
 rtl/conv_symbol_deserializer.sv | 83 ++++++++
 tb/tb_conv_symbol_deserializer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/conv_symbol_deserializer.sv
// conv_symbol_deserializer: pairs the alternating G0 / inverted-G1 symbol stream into (c0,c1) for the Viterbi decoder.
// G1_INVERT_EN defined: c1 = ~DataI (undoes the transmitter's G1 inversion); undefined: c1 = DataI.
module conv_symbol_deserializer #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             DataI,
  input  logic             DataI_en,
  input  logic             Slip,
  input  logic             Pair_ready,
  input  logic             Ovr_clr,
  output logic             c0,
  output logic             c1,
  output logic             Pair_valid,
  output logic             Phase,
  output logic             Overrun,
  output logic [CNT_W-1:0] Pair_cnt
);
  logic             ph_q, ph_d;
  logic             stage_q, stage_d;
  logic             slip_pend_q, slip_pend_d;
  logic             c0_q, c0_d;
  logic             c1_q, c1_d;
  logic             pv_q, pv_d;
  logic             phase_q, phase_d;
  logic             ovr_q, ovr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             g1;
  logic             discard, accept, pair_done, load, drop;
`ifdef G1_INVERT_EN
  assign g1 = ~DataI;
`else
  assign g1 = DataI;
`endif
  // a strobe arriving with Slip or a pending slip is thrown away instead of being kept
  always_comb begin
    discard     = DataI_en && (slip_pend_q || Slip);
    accept      = DataI_en && !discard;
    pair_done   = accept && ph_q;
    load        = pair_done && (!pv_q || Pair_ready);
    drop        = pair_done && pv_q && !Pair_ready;
    slip_pend_d = discard ? 1'b0 : (Slip ? 1'b1 : slip_pend_q);
    phase_d     = discard ? ~phase_q : phase_q;
    ph_d        = accept ? ~ph_q : ph_q;
    stage_d     = (accept && !ph_q) ? DataI : stage_q;
    c0_d        = load ? stage_q : c0_q;
    c1_d        = load ? g1 : c1_q;
    pv_d        = load ? 1'b1 : ((pv_q && Pair_ready) ? 1'b0 : pv_q);
    ovr_d       = drop | (ovr_q & ~Ovr_clr);
    cnt_d       = load ? cnt_q + 1'b1 : cnt_q;
  end
  // state registers; reset discards any partially assembled pair
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ph_q        <= 1'b0;
      stage_q     <= 1'b0;
      slip_pend_q <= 1'b0;
      c0_q        <= 1'b0;
      c1_q        <= 1'b0;
      pv_q        <= 1'b0;
      phase_q     <= 1'b0;
      ovr_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      ph_q        <= ph_d;
      stage_q     <= stage_d;
      slip_pend_q <= slip_pend_d;
      c0_q        <= c0_d;
      c1_q        <= c1_d;
      pv_q        <= pv_d;
      phase_q     <= phase_d;
      ovr_q       <= ovr_d;
      cnt_q       <= cnt_d;
    end
  end
  assign c0         = c0_q;
  assign c1         = c1_q;
  assign Pair_valid = pv_q;
  assign Phase      = phase_q;
  assign Overrun    = ovr_q;
  assign Pair_cnt   = cnt_q;
endmodule

// File: tb/tb_conv_symbol_deserializer.sv
// tb_conv_symbol_deserializer: directed checks of pairing, polarity, slip, backpressure, wrap and reset.
module tb_conv_symbol_deserializer;
`ifdef G1_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif
  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       DataI = 1'b0, DataI_en = 1'b0, Slip = 1'b0, Pair_ready = 1'b1, Ovr_clr = 1'b0;
  logic       c0, c1, Pair_valid, Phase, Overrun;
  logic [3:0] Pair_cnt;
  int         checks = 0;
  int         errors = 0;

  conv_symbol_deserializer #(.CNT_W(4)) dut (
    .Clk(Clk), .Rst(Rst), .DataI(DataI), .DataI_en(DataI_en), .Slip(Slip),
    .Pair_ready(Pair_ready), .Ovr_clr(Ovr_clr), .c0(c0), .c1(c1),
    .Pair_valid(Pair_valid), .Phase(Phase), .Overrun(Overrun), .Pair_cnt(Pair_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic b, input logic s);
    DataI = b; DataI_en = 1'b1; Slip = s;
    @(posedge Clk); #1;
    DataI_en = 1'b0; Slip = 1'b0;
  endtask

  task automatic idle();
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    @(negedge Clk); Rst = 1'b0;
    @(negedge Clk); Rst = 1'b1;
  endtask

  initial begin
    #2;
    chk("rst_async_c0", c0, 0);
    chk("rst_async_pv", Pair_valid, 0);
    @(negedge Clk); Rst = 1'b1;
    chk("rst_c1", c1, 0);
    chk("rst_phase", Phase, 0);
    chk("rst_ovr", Overrun, 0);
    chk("rst_cnt", Pair_cnt, 0);
    // pair assembly: 1,0,0,1
    send(1'b1, 1'b0);
    chk("asm_b1_pv", Pair_valid, 0);
    send(1'b0, 1'b0);
    chk("asm_p1_pv", Pair_valid, 1);
    chk("asm_p1_c0", c0, 1);
    chk("asm_p1_c1", c1, 0 ^ INV);
    chk("asm_p1_cnt", Pair_cnt, 1);
    send(1'b0, 1'b0);
    chk("asm_b3_pv", Pair_valid, 0);
    send(1'b1, 1'b0);
    chk("asm_p2_pv", Pair_valid, 1);
    chk("asm_p2_c0", c0, 0);
    chk("asm_p2_c1", c1, 1 ^ INV);
    chk("asm_p2_cnt", Pair_cnt, 2);
    idle();
    chk("asm_pv_clr", Pair_valid, 0);
    // slip together with first bit: 1 discarded, then pair (1,0)
    send(1'b1, 1'b1);
    chk("slip_phase", Phase, 1);
    chk("slip_pv", Pair_valid, 0);
    send(1'b1, 1'b0);
    chk("slip_b2_pv", Pair_valid, 0);
    send(1'b0, 1'b0);
    chk("slip_pv2", Pair_valid, 1);
    chk("slip_c0", c0, 1);
    chk("slip_c1", c1, 0 ^ INV);
    chk("slip_cnt", Pair_cnt, 3);
    idle();
    // standalone slip pulses, second one ignored, next strobe discarded
    Slip = 1'b1; idle(); idle(); Slip = 1'b0;
    chk("slip_pend_phase", Phase, 1);
    send(1'b1, 1'b0);
    chk("slip2_phase", Phase, 0);
    send(1'b0, 1'b0);
    chk("slip2_b2_pv", Pair_valid, 0);
    send(1'b1, 1'b0);
    chk("slip2_c0", c0, 0);
    chk("slip2_c1", c1, 1 ^ INV);
    chk("slip2_cnt", Pair_cnt, 4);
    idle();
    // backpressure: second pair dropped
    Pair_ready = 1'b0;
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    chk("bp_p1_pv", Pair_valid, 1);
    chk("bp_p1_cnt", Pair_cnt, 5);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    chk("bp_hold_c0", c0, 1);
    chk("bp_hold_c1", c1, 0 ^ INV);
    chk("bp_hold_pv", Pair_valid, 1);
    chk("bp_ovr", Overrun, 1);
    chk("bp_cnt", Pair_cnt, 5);
    idle();
    chk("bp_ovr_sticky", Overrun, 1);
    Ovr_clr = 1'b1; idle(); Ovr_clr = 1'b0;
    chk("bp_ovr_clr", Overrun, 0);
    Pair_ready = 1'b1; idle();
    chk("bp_release_pv", Pair_valid, 0);
    // overrun set wins over clear in the same cycle
    Pair_ready = 1'b0;
    send(1'b0, 1'b0); send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    Ovr_clr = 1'b1;
    send(1'b0, 1'b0);
    Ovr_clr = 1'b0;
    chk("ovr_set_wins", Overrun, 1);
    chk("ovr_set_cnt", Pair_cnt, 6);
    Pair_ready = 1'b1; Ovr_clr = 1'b1; idle(); Ovr_clr = 1'b0;
    // counter wrap with CNT_W=4
    do_reset();
    chk("wrap_rst_cnt", Pair_cnt, 0);
    chk("wrap_rst_ovr", Overrun, 0);
    for (int i = 0; i < 17; i++) begin
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
    end
    chk("wrap_cnt", Pair_cnt, 1);
    idle();
    // reset mid-pair: stale staged bit must not be used
    do_reset();
    send(1'b1, 1'b0);
    do_reset();
    chk("mid_rst_cnt", Pair_cnt, 0);
    send(1'b0, 1'b0);
    chk("mid_b1_pv", Pair_valid, 0);
    send(1'b0, 1'b0);
    chk("mid_pv", Pair_valid, 1);
    chk("mid_c0", c0, 0);
    chk("mid_c1", c1, 0 ^ INV);
    chk("mid_cnt", Pair_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
